instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
Fetch stage directly upstream of the instruction memory in the multi-cycle CPU. It owns the program counter and drives the memory's read address and read/write select. It captures the returned 32-bit big-endian word into the instruction register (IR) and signals completion to the control unit. It also computes next-PC for the sequential, branch, jump-register and jump cases.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
MEM_LATENCY, 0, extra wait cycles between driving IAddr and sampling IMemData (0..15).
MEM_BYTES, 256, instruction memory size in bytes; fetch addresses must be < MEM_BYTES-3.

Ports:
CLK  in  1  clock, all state updates on rising edge.
Reset  in  1  synchronous, active-high reset.
FetchReq  in  1  control unit requests a fetch at the current PC (level; sampled only in IDLE).
PCWrite  in  1  update PC this edge using PCSrc.
PCSrc  in  2  next-PC select: 00 PC+4, 01 branch, 10 RegRs, 11 jump.
ExtImm  in  32  sign-extended 16-bit branch offset (word units).
JumpTarget  in  26  J-type target field.
RegRs  in  32  register value for jr.
IMemData  in  32  word returned by instruction memory.
IAddr  out  32  byte address to instruction memory (registered).
InsMemRW  out  1  memory read/write select; constant 1 (read).
IR  out  32  instruction register.
PC  out  32  current program counter.
PC4  out  32  PC+4 (combinational).
FetchDone  out  1  one-cycle pulse: IR holds the new instruction.
Fault  out  1  one-cycle pulse: fetch rejected (misaligned or out of range).
Busy  out  1  high while state is WAIT.

Behaviour:
- Reset (any state, including mid-fetch): state=IDLE, PC=RESET_PC, IAddr=RESET_PC, IR=0, FetchDone=0, Fault=0, wait counter=0. InsMemRW is 1 always, including during reset.
- FSM has 2 states, IDLE and WAIT. FetchDone and Fault default to 0 every edge unless set below.
- IDLE, FetchReq=1, PC[1:0]==0 and PC <= MEM_BYTES-4: IAddr<=PC, cnt<=MEM_LATENCY, go to WAIT.
- IDLE, FetchReq=1 with a misaligned or out-of-range PC: Fault<=1, stay in IDLE. IAddr and IR are unchanged.
- WAIT, cnt!=0: cnt<=cnt-1.
- WAIT, cnt==0: IR<=IMemData, FetchDone<=1, go to IDLE.
- Latency: when FetchReq is sampled at edge E0, FetchDone and the new IR are visible after edge E0+MEM_LATENCY+1. For MEM_LATENCY=0 this is the next edge.
- FetchReq while in WAIT is ignored; requests are not queued. FetchReq held high in IDLE starts back-to-back fetches: a new fetch starts on the same edge that FetchDone falls.
- IAddr is stable for the whole of WAIT and is independent of later PC changes.
- PC update is independent of FSM state. On an edge with PCWrite=1, PC<= next:
  - 00: PC+4.
  - 01: PC+4+(ExtImm<<2).
  - 10: RegRs.
  - 11: {PC4[31:28], JumpTarget, 2'b00}.
- All PC arithmetic is 32-bit, modulo 2^32, and wraps silently. No alignment check happens on PC write; misalignment is reported only at fetch time.
- FetchReq and PCWrite on the same IDLE edge: the fetch uses the old PC, and PC takes the new value.
- Reset and any other input on the same edge: reset wins.
- IR holds its value until the next successful capture. A Fault does not clear IR.

Test Plan:
- Reset, then FetchReq pulse, MEM_LATENCY=0, memory holds 0x02324020 at byte 0 -> IAddr=0, FetchDone pulse one edge later, IR=0x02324020, PC=0.
- MEM_LATENCY=3, FetchReq at PC=0x10 -> Busy high for 4 cycles, FetchDone after E0+4, IAddr held at 0x10 throughout. A FetchReq pulse during WAIT produces no second fetch.
- PCWrite with each PCSrc from PC=0x00000020, ExtImm=0xFFFFFFFE, RegRs=0x40, JumpTarget=0x0000010 -> PC=0x24, 0x1C, 0x40, 0x00000040 respectively. PC=0xFFFFFFFC with PCSrc=00 -> PC=0x00000000.
- PC=0x06 (misaligned) or PC=0x100 (MEM_BYTES=256) with FetchReq -> Fault pulse, no WAIT, IR unchanged. PC=0xFC fetches normally.
- FetchReq and PCWrite(00) on the same edge at PC=0x8 -> IAddr=0x8, PC=0xC. Reset asserted mid-WAIT -> next edge IDLE, IR=0, PC=RESET_PC, no FetchDone.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch stage of the multi-cycle CPU. Owns the program counter, issues a
// registered read address to instruction memory, waits MEM_LATENCY extra
// cycles, then captures the returned big-endian word into the instruction
// register and pulses FetchDone. Fetches from a misaligned or out-of-range PC
// are rejected with a one-cycle Fault pulse. Next-PC selection (sequential,
// branch, jump-register, jump) is applied whenever PCWrite is high,
// independent of the fetch state machine.
//
// Ports:
//   CLK        in   1   clock, rising edge
//   Reset      in   1   synchronous active-high reset
//   FetchReq   in   1   fetch request at current PC (sampled in IDLE only)
//   PCWrite    in   1   load PC with the PCSrc-selected next value
//   PCSrc      in   2   00 PC+4, 01 branch, 10 RegRs, 11 jump
//   ExtImm     in  32   sign-extended branch offset in words
//   JumpTarget in  26   J-type target field
//   RegRs      in  32   register value for jr
//   IMemData   in  32   word returned by instruction memory
//   IAddr      out 32   registered byte address to instruction memory
//   InsMemRW   out  1   read/write select, always 1 (read)
//   IR         out 32   instruction register
//   PC         out 32   program counter
//   PC4        out 32   PC+4 (combinational)
//   FetchDone  out  1   one-cycle pulse, IR holds the new instruction
//   Fault      out  1   one-cycle pulse, fetch rejected
//   Busy       out  1   high while waiting on memory
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_LATENCY = 0,
    parameter int unsigned MEM_BYTES   = 256
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        FetchReq,
    input  logic        PCWrite,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] ExtImm,
    input  logic [25:0] JumpTarget,
    input  logic [31:0] RegRs,
    input  logic [31:0] IMemData,
    output logic [31:0] IAddr,
    output logic        InsMemRW,
    output logic [31:0] IR,
    output logic [31:0] PC,
    output logic [31:0] PC4,
    output logic        FetchDone,
    output logic        Fault,
    output logic        Busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Highest byte address at which a full word still fits in memory.
    localparam logic [31:0] LAST_FETCH_ADDR = 32'(MEM_BYTES - 4);
    localparam logic [3:0]  LATENCY_INIT    = 4'(MEM_LATENCY);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] iaddr_q;
    logic [31:0] ir_q;
    logic        fetch_done_q;
    logic        fault_q;
    logic [31:0] pc4;
    logic        fetch_ok;

    assign pc4      = pc_q + 32'd4;
    assign fetch_ok = (pc_q[1:0] == 2'b00) && (pc_q <= LAST_FETCH_ADDR);

    // Next-PC select. All arithmetic wraps modulo 2^32.
    // NOTE: every signal driven in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        pc_d = pc4;
        unique case (PCSrc)
            2'b00: pc_d = pc4;
            2'b01: pc_d = pc4 + (ExtImm << 2);
            2'b10: pc_d = RegRs;
            2'b11: pc_d = {pc4[31:28], JumpTarget, 2'b00};
            default: pc_d = pc4;
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values; this is what lets a fetch use the old PC
    // while PCWrite loads the new one on the same edge.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            pc_q         <= RESET_PC;
            iaddr_q      <= RESET_PC;
            ir_q         <= 32'd0;
            fetch_done_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            fetch_done_q <= 1'b0;
            fault_q      <= 1'b0;

            if (PCWrite) begin
                pc_q <= pc_d;
            end

            case (state_q)
                ST_IDLE: begin
                    if (FetchReq) begin
                        if (fetch_ok) begin
                            iaddr_q <= pc_q;
                            cnt_q   <= LATENCY_INIT;
                            state_q <= ST_WAIT;
                        end else begin
                            fault_q <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    // FetchReq is deliberately ignored here; requests are not queued.
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        ir_q         <= IMemData;
                        fetch_done_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign IAddr     = iaddr_q;
    assign InsMemRW  = 1'b1;
    assign IR        = ir_q;
    assign PC        = pc_q;
    assign PC4       = pc4;
    assign FetchDone = fetch_done_q;
    assign Fault     = fault_q;
    assign Busy      = (state_q == ST_WAIT);

endmodule
